pipe_hazard_ctrl: RTL

Hazard and stall controller for the 5-stage RISC-V pipeline. It generates the enable, flush and bubble controls for the PC, IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, covering three cases:
- load-use hazards,
- taken-branch flushes,
- variable-latency data-memory waits, with a timeout abort.

It sits beside the pipeline registers and is the only source of their stall and flush controls.

---
 rtl/pipe_hazard_ctrl_if.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard inputs from the pipeline and the stall/flush controls
// returned to the pipeline registers.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwen;
  logic [1:0]       ex_wbsel;
  logic             ex_br_taken;
  logic             mem_valid;
  logic             mem_ready;
  logic             stat_clr;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: supplies hazard information, consumes controls
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwen,
           ex_wbsel, ex_br_taken, mem_valid, mem_ready, stat_clr,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_bubble, mem_err, stall_cnt
  );

  // Controller side
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwen,
           ex_wbsel, ex_br_taken, mem_valid, mem_ready, stat_clr,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
           mem_wb_bubble, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: load-use stalls,
// taken-branch flushes and data-memory wait freezes with timeout abort.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  pipe_hazard_ctrl_if.slave  bus
);
  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic freeze;
  logic stall_evt;

  // Hazard detection and the state-dependent memory freeze
  always_comb begin
    load_use = bus.ex_regwen && (bus.ex_wbsel == 2'b00) && (bus.ex_rd != 5'd0) &&
               ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));
    case (state_q)
      ST_RUN:  freeze = bus.mem_valid && !bus.mem_ready;
      ST_WAIT: freeze = !bus.mem_ready;
      default: freeze = 1'b0;
    endcase
    // A load-use under a taken branch is squashed, so it costs no stall
    stall_evt = freeze || (load_use && !bus.ex_br_taken);
  end

  // Priority-ordered pipeline register controls (freeze > branch > load-use)
  always_comb begin
    bus.pc_en         = 1'b1;
    bus.if_id_en      = 1'b1;
    bus.id_ex_en      = 1'b1;
    bus.ex_mem_en     = 1'b1;
    bus.if_id_flush   = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.mem_wb_bubble = 1'b0;
    if (freeze) begin
      // Hold the memory op in EX_MEM; the op ahead retires, nothing follows it
      bus.pc_en         = 1'b0;
      bus.if_id_en      = 1'b0;
      bus.id_ex_en      = 1'b0;
      bus.ex_mem_en     = 1'b0;
      bus.mem_wb_bubble = 1'b1;
    end else if (bus.ex_br_taken) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
    end else if (load_use) begin
      bus.pc_en       = 1'b0;
      bus.if_id_en    = 1'b0;
      bus.id_ex_flush = 1'b1;
    end
    // The aborted access must not write back while the pipeline moves on
    if (state_q == ST_ABORT) begin
      bus.mem_wb_bubble = 1'b1;
    end
  end

  // Memory-wait FSM next state, timeout counter and error pulse
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.mem_valid && !bus.mem_ready) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WC_W'(TIMEOUT)) begin
          state_d    = ST_ABORT;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Saturating stall statistics; a clear discards the same-cycle increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.stat_clr) begin
      stall_cnt_d = '0;
    end else if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule
